// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt/sll, iterative shift-add multiply.
// Results and flags are registered and held until the next completion.
module ula_multiciclo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   input  logic [2:0]       operation,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int SH = $clog2(WIDTH);
   localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

   // state | meaning
   // IDLE  | accepting requests, single-cycle ops complete here
   // MUL   | shift-add multiply running, one multiplier bit per cycle
   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [SH-1:0]    cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             overflow_q, overflow_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_res, acc_next;
   logic             alu_c, alu_v;

   always_comb begin
      sum     = {1'b0, operand1} + {1'b0, operand2};
      diff    = {1'b0, operand1} - {1'b0, operand2};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (operation)
         3'b000: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
         end
         3'b001: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);
         end
         3'b010: alu_res = operand1 & operand2;
         3'b011: alu_res = operand1 | operand2;
         3'b100: alu_res = operand1 ^ operand2;
         3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
         3'b110: alu_res = operand1 << operand2[SH-1:0];
         default: alu_res = '0;
      endcase
   end

   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      zero_d     = zero_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (operation == 3'b111) begin
                  mcand_d  = operand1;
                  mplier_d = operand2;
                  acc_d    = '0;
                  cnt_d    = CNT_LAST;
                  state_d  = MUL;
               end else begin
                  result_d   = alu_res;
                  zero_d     = (alu_res == '0);
                  carry_d    = alu_c;
                  overflow_d = alu_v;
                  done_d     = 1'b1;
               end
            end
         end
         MUL: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // Last bit folds straight into result so completion lands WIDTH edges after capture
            if (cnt_q == '0) begin
               result_d   = acc_next;
               zero_d     = (acc_next == '0);
               carry_d    = 1'b0;
               overflow_d = 1'b0;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         carry_q    <= carry_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign result   = result_q;
   assign zero     = zero_q;
   assign carry    = carry_q;
   assign overflow = overflow_q;
   assign busy     = (state_q == MUL);
   assign done     = done_q;

endmodule
